// File: rtl/gb_cpu_interrupt_ctrl.sv
// gb_cpu_interrupt_ctrl
//   IE/IF/IME storage, fixed-priority arbitration (bit 0 wins), ISR dispatch
//   request at instruction boundaries, EI one-instruction delay and the HALT
//   sleep/wake sequence including the HALT-bug pulse.
module gb_cpu_interrupt_ctrl #(
  parameter int          NUM_IRQ       = 5,
  parameter logic [15:0] VECTOR_BASE   = 16'h0040,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0008
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m_tick_i,
  input  logic               instr_boundary_i,
  input  logic               enable_ints_i,
  input  logic               disable_ints_i,
  input  logic               write_vector_i,
  input  logic               clear_flag_i,
  input  logic               halt_req_i,
  input  logic               dispatch_ack_i,
  input  logic [NUM_IRQ-1:0] irq_src_i,
  input  logic               wr_if_i,
  input  logic               wr_ie_i,
  input  logic [7:0]         reg_wdata_i,
  output logic [7:0]         if_q_o,
  output logic [7:0]         ie_q_o,
  output logic               ime_o,
  output logic               int_pending_o,
  output logic               dispatch_req_o,
  output logic [15:0]        int_vector_o,
  output logic               halted_o,
  output logic               halt_bug_o
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_HALT     = 2'd1;
  localparam logic [1:0] ST_DISPATCH = 2'd2;

  logic [NUM_IRQ-1:0] if_q, if_d;
  logic [7:0]         ie_q, ie_d;
  logic               ime_q, ime_d;
  logic               ei_arm_q, ei_arm_d;
  logic [1:0]         state_q, state_d;
  logic [15:0]        vec_q, vec_d;
  logic               hbug_q, hbug_d;

  logic [NUM_IRQ-1:0] pend_vec;
  logic [NUM_IRQ-1:0] if_ld;
  logic [NUM_IRQ-1:0] clr_mask;
  logic [2:0]         pend_idx;
  logic               pend_found;
  logic               pending;
  logic               ime_eff;
  logic               take_disp;

  assign pend_vec = ie_q[NUM_IRQ-1:0] & if_q;
  assign pending  = |pend_vec;

  // An EI armed by an earlier tick becomes effective on this boundary tick, so
  // the instruction after EI can be followed directly by a dispatch.
  assign ime_eff   = ime_q | (ei_arm_q & instr_boundary_i);
  assign take_disp = m_tick_i & (state_q == ST_RUN) & instr_boundary_i & ime_eff & pending;

  // Priority encoder: lowest-index pending source (used for the vector)
  always_comb begin
    pend_idx   = 3'd0;
    pend_found = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (!pend_found && pend_vec[i]) begin
        pend_idx   = i[2:0];
        pend_found = 1'b1;
      end
    end
  end

  // IF next state: register write, then acknowledge-clear, then new requests
  always_comb begin
    if_ld    = if_q;
    clr_mask = '0;
    if (wr_if_i) if_ld = reg_wdata_i[NUM_IRQ-1:0];
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (ie_q[i] && if_ld[i]) begin
        clr_mask    = '0;
        clr_mask[i] = 1'b1;
      end
    end
    if_d = if_ld;
    if (m_tick_i && clear_flag_i) if_d = if_ld & ~clr_mask;
    if_d = if_d | irq_src_i;
  end

  // IE next state: plain register, all 8 bits kept for readback
  always_comb begin
    ie_d = ie_q;
    if (wr_ie_i) ie_d = reg_wdata_i;
  end

  // IME / EI-arm next state; dispatch and DI both dominate EI
  always_comb begin
    ime_d    = ime_q;
    ei_arm_d = ei_arm_q;
    if (m_tick_i) begin
      if (take_disp || disable_ints_i) begin
        ime_d    = 1'b0;
        ei_arm_d = 1'b0;
      end else begin
        if (ei_arm_q && instr_boundary_i) begin
          ime_d    = 1'b1;
          ei_arm_d = 1'b0;
        end
        if (enable_ints_i && !ime_q) ei_arm_d = 1'b1;
      end
    end
  end

  // Vector latch: 0 when nothing is pending (e.g. IE cleared mid-dispatch)
  always_comb begin
    vec_d = vec_q;
    if (m_tick_i && write_vector_i) begin
      if (pend_found) vec_d = VECTOR_BASE + VECTOR_STRIDE * {13'd0, pend_idx};
      else            vec_d = 16'h0000;
    end
  end

  // Sequencer: RUN / HALT / DISPATCH and the HALT-bug pulse
  always_comb begin
    state_d = state_q;
    hbug_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (take_disp) begin
          state_d = ST_DISPATCH;
        end else if (m_tick_i && halt_req_i) begin
          if (!pending)    state_d = ST_HALT;
          else if (!ime_q) hbug_d  = 1'b1;
        end
      end
      ST_HALT: begin
        // wake is not gated by m_tick or IME
        if (pending) state_d = ST_RUN;
      end
      ST_DISPATCH: begin
        if (dispatch_ack_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_q     <= '0;
      ie_q     <= '0;
      ime_q    <= 1'b0;
      ei_arm_q <= 1'b0;
      state_q  <= ST_RUN;
      vec_q    <= 16'h0000;
      hbug_q   <= 1'b0;
    end else begin
      if_q     <= if_d;
      ie_q     <= ie_d;
      ime_q    <= ime_d;
      ei_arm_q <= ei_arm_d;
      state_q  <= state_d;
      vec_q    <= vec_d;
      hbug_q   <= hbug_d;
    end
  end

  // Output mapping; unused IF bits read as 1
  always_comb begin
    if_q_o              = 8'hFF;
    if_q_o[NUM_IRQ-1:0] = if_q;
  end

  assign ie_q_o         = ie_q;
  assign ime_o          = ime_q;
  assign int_pending_o  = pending;
  assign dispatch_req_o = (state_q == ST_DISPATCH);
  assign int_vector_o   = vec_q;
  assign halted_o       = (state_q == ST_HALT);
  assign halt_bug_o     = hbug_q;

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
// Directed bench for gb_cpu_interrupt_ctrl: a vector table for the main
// arbitration / IME / IF behaviour plus hand sequences for HALT and reset.
module tb_gb_cpu_interrupt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_tick, bnd, ei, di, wv, cf, hr, ack, wif, wie;
  logic [4:0]  irq;
  logic [7:0]  wd;
  logic [7:0]  if_q, ie_q;
  logic        ime, pend, dreq, halted, hbug;
  logic [15:0] vec;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gb_cpu_interrupt_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .m_tick_i(m_tick), .instr_boundary_i(bnd),
    .enable_ints_i(ei), .disable_ints_i(di),
    .write_vector_i(wv), .clear_flag_i(cf),
    .halt_req_i(hr), .dispatch_ack_i(ack),
    .irq_src_i(irq), .wr_if_i(wif), .wr_ie_i(wie), .reg_wdata_i(wd),
    .if_q_o(if_q), .ie_q_o(ie_q), .ime_o(ime), .int_pending_o(pend),
    .dispatch_req_o(dreq), .int_vector_o(vec), .halted_o(halted),
    .halt_bug_o(hbug)
  );

  typedef struct {
    logic        mt, bnd, ei, di, wv, cf, hr, ack;
    logic [4:0]  irq;
    logic        wif, wie;
    logic [7:0]  wd;
    logic [7:0]  e_if, e_ie;
    logic        e_ime, e_pend, e_dreq;
    logic [15:0] e_vec;
    logic        e_halt;
  } vec_t;

  vec_t tv[32];

  function automatic vec_t V(input logic mt_, bnd_, ei_, di_, wv_, cf_, hr_, ack_,
                             input logic [4:0] irq_, input logic wif_, wie_,
                             input logic [7:0] wd_, input logic [7:0] eif, eie,
                             input logic eime, epend, edreq, input logic [15:0] evec,
                             input logic ehalt);
    vec_t v;
    v.mt = mt_; v.bnd = bnd_; v.ei = ei_; v.di = di_; v.wv = wv_; v.cf = cf_;
    v.hr = hr_; v.ack = ack_; v.irq = irq_; v.wif = wif_; v.wie = wie_; v.wd = wd_;
    v.e_if = eif; v.e_ie = eie; v.e_ime = eime; v.e_pend = epend; v.e_dreq = edreq;
    v.e_vec = evec; v.e_halt = ehalt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic idle();
    m_tick = 0; bnd = 0; ei = 0; di = 0; wv = 0; cf = 0; hr = 0; ack = 0;
    irq = '0; wif = 0; wie = 0; wd = '0;
  endtask

  // one clock: inputs already driven after a negedge, sample at the next negedge
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int pulses;
    idle();
    rst_n = 1'b0;
    #3;
    chk("rst if_q", {8'h0, if_q}, 16'h00E0);
    chk("rst ie_q", {8'h0, ie_q}, 16'h0000);
    chk("rst ime/dreq/halted/hbug", {12'h0, ime, dreq, halted, hbug}, 16'h0000);
    chk("rst vec", vec, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    //         mt bnd ei di wv cf hr ack irq     wif wie wd     e_if   e_ie   ime pnd drq vec       hlt
    tv[0]  = V(1, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 1, 8'h04, 8'hE0, 8'h04, 0, 0, 0, 16'h0000, 0);
    tv[1]  = V(1, 1, 1, 0, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE0, 8'h04, 0, 0, 0, 16'h0000, 0);
    tv[2]  = V(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE0, 8'h04, 1, 0, 0, 16'h0000, 0);
    tv[3]  = V(1, 0, 0, 0, 0, 0, 0, 0, 5'h04, 0, 0, 8'h00, 8'hE4, 8'h04, 1, 1, 0, 16'h0000, 0);
    tv[4]  = V(0, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE4, 8'h04, 1, 1, 0, 16'h0000, 0);
    tv[5]  = V(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE4, 8'h04, 0, 1, 1, 16'h0000, 0);
    tv[6]  = V(1, 0, 0, 0, 1, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE4, 8'h04, 0, 1, 1, 16'h0050, 0);
    tv[7]  = V(1, 0, 0, 0, 0, 1, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE0, 8'h04, 0, 0, 1, 16'h0050, 0);
    tv[8]  = V(0, 0, 0, 0, 0, 0, 0, 1, 5'h00, 0, 0, 8'h00, 8'hE0, 8'h04, 0, 0, 0, 16'h0050, 0);
    tv[9]  = V(1, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 1, 8'h1F, 8'hE0, 8'h1F, 0, 0, 0, 16'h0050, 0);
    tv[10] = V(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 1, 0, 8'h1A, 8'hFA, 8'h1F, 0, 1, 0, 16'h0050, 0);
    tv[11] = V(1, 0, 0, 0, 1, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hFA, 8'h1F, 0, 1, 0, 16'h0048, 0);
    tv[12] = V(1, 0, 0, 0, 0, 1, 0, 0, 5'h00, 0, 0, 8'h00, 8'hF8, 8'h1F, 0, 1, 0, 16'h0048, 0);
    tv[13] = V(1, 0, 0, 0, 0, 1, 0, 0, 5'h08, 0, 0, 8'h00, 8'hF8, 8'h1F, 0, 1, 0, 16'h0048, 0);
    tv[14] = V(0, 0, 0, 0, 0, 0, 0, 0, 5'h10, 1, 0, 8'h00, 8'hF0, 8'h1F, 0, 1, 0, 16'h0048, 0);
    tv[15] = V(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 1, 0, 8'h00, 8'hE0, 8'h1F, 0, 0, 0, 16'h0048, 0);
    tv[16] = V(1, 1, 1, 1, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE0, 8'h1F, 0, 0, 0, 16'h0048, 0);
    tv[17] = V(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE0, 8'h1F, 0, 0, 0, 16'h0048, 0);
    tv[18] = V(1, 0, 0, 0, 0, 0, 0, 0, 5'h00, 1, 1, 8'h01, 8'hE1, 8'h01, 0, 1, 0, 16'h0048, 0);
    tv[19] = V(1, 1, 1, 0, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE1, 8'h01, 0, 1, 0, 16'h0048, 0);
    tv[20] = V(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE1, 8'h01, 0, 1, 1, 16'h0048, 0);
    tv[21] = V(1, 0, 0, 0, 0, 1, 0, 1, 5'h00, 0, 0, 8'h00, 8'hE0, 8'h01, 0, 0, 0, 16'h0048, 0);
    tv[22] = V(1, 0, 0, 0, 0, 0, 0, 0, 5'h04, 0, 1, 8'h04, 8'hE4, 8'h04, 0, 1, 0, 16'h0048, 0);
    tv[23] = V(1, 1, 1, 0, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE4, 8'h04, 0, 1, 0, 16'h0048, 0);
    tv[24] = V(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE4, 8'h04, 0, 1, 1, 16'h0048, 0);
    tv[25] = V(0, 0, 0, 0, 0, 0, 0, 0, 5'h00, 0, 1, 8'h00, 8'hE4, 8'h00, 0, 0, 1, 16'h0048, 0);
    tv[26] = V(1, 0, 0, 0, 1, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE4, 8'h00, 0, 0, 1, 16'h0000, 0);
    tv[27] = V(0, 0, 0, 0, 0, 0, 0, 1, 5'h00, 1, 0, 8'h00, 8'hE0, 8'h00, 0, 0, 0, 16'h0000, 0);
    tv[28] = V(1, 1, 1, 0, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE0, 8'h00, 0, 0, 0, 16'h0000, 0);
    tv[29] = V(1, 1, 0, 0, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE0, 8'h00, 1, 0, 0, 16'h0000, 0);
    tv[30] = V(1, 1, 1, 0, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE0, 8'h00, 1, 0, 0, 16'h0000, 0);
    tv[31] = V(1, 0, 0, 1, 0, 0, 0, 0, 5'h00, 0, 0, 8'h00, 8'hE0, 8'h00, 0, 0, 0, 16'h0000, 0);

    for (int i = 0; i < 32; i++) begin
      m_tick = tv[i].mt; bnd = tv[i].bnd; ei = tv[i].ei; di = tv[i].di;
      wv = tv[i].wv; cf = tv[i].cf; hr = tv[i].hr; ack = tv[i].ack;
      irq = tv[i].irq; wif = tv[i].wif; wie = tv[i].wie; wd = tv[i].wd;
      tick();
      chk($sformatf("v%0d if_q", i), {8'h0, if_q}, {8'h0, tv[i].e_if});
      chk($sformatf("v%0d ie_q", i), {8'h0, ie_q}, {8'h0, tv[i].e_ie});
      chk($sformatf("v%0d ime/pend/dreq/halted", i), {12'h0, ime, pend, dreq, halted},
          {12'h0, tv[i].e_ime, tv[i].e_pend, tv[i].e_dreq, tv[i].e_halt});
      chk($sformatf("v%0d vec", i), vec, tv[i].e_vec);
    end
    idle();

    // HALT with IME=0 and nothing pending: sleep, wake one clk after request
    wie = 1; wd = 8'h01; m_tick = 1; tick(); idle();
    hr = 1; m_tick = 1; bnd = 1; tick(); idle();
    chk("halt entered", {15'h0, halted}, 16'h0001);
    chk("halt no bug", {15'h0, hbug}, 16'h0000);
    irq = 5'h01; tick(); idle();
    chk("halt wake latency", {14'h0, halted, pend}, 16'h0003);
    tick();
    chk("halt woke", {14'h0, halted, dreq}, 16'h0000);

    // HALT with IF pending and IME=0: no sleep, single halt_bug pulse
    hr = 1; m_tick = 1; bnd = 1; tick(); idle();
    chk("hbug pulse", {14'h0, hbug, halted}, 16'h0002);
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (hbug) pulses++;
    end
    chk("hbug single pulse", 16'(pulses), 16'h0000);
    chk("hbug no dispatch", {15'h0, dreq}, 16'h0000);

    // Reset asserted mid-dispatch clears everything without a clock edge
    ei = 1; m_tick = 1; bnd = 1; tick(); idle();
    m_tick = 1; bnd = 1; tick(); idle();
    chk("pre-rst dreq", {15'h0, dreq}, 16'h0001);
    wv = 1; m_tick = 1; tick(); idle();
    chk("pre-rst vec", vec, 16'h0040);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst dreq/ime/halted", {13'h0, dreq, ime, halted}, 16'h0000);
    chk("async rst if/ie", {if_q, ie_q}, 16'hE000);
    chk("async rst vec", vec, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post-rst stable", {12'h0, dreq, pend, ime, halted}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
